tmds_video_core: RTL and testbench

TMDS_VIDEO_CORE -- requirements
Module: tmds_video_core

---
 rtl/tmds_video_core_if.sv | 30 +++
 rtl/tmds_video_core.sv | 159 +++++++++++++++
 tb/tb_tmds_video_core.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tmds_video_core_if.sv
// Pixel input and timing/TMDS output bundle of tmds_video_core.
// The master side is the core: it consumes pixels and drives timing and symbols.
interface tmds_video_core_if #(
    parameter int unsigned POS_WIDTH = 11
);
    logic [7:0]           red;
    logic [7:0]           green;
    logic [7:0]           blue;
    logic [POS_WIDTH-1:0] hpos;
    logic [POS_WIDTH-1:0] vpos;
    logic                 in_hblank;
    logic                 in_vblank;
    logic                 frame_start;
    logic [15:0]          frame_count;
    logic [9:0]           tmds_0;
    logic [9:0]           tmds_1;
    logic [9:0]           tmds_2;

    modport master (
        input  red, green, blue,
        output hpos, vpos, in_hblank, in_vblank, frame_start, frame_count,
        output tmds_0, tmds_1, tmds_2
    );

    modport slave (
        output red, green, blue,
        input  hpos, vpos, in_hblank, in_vblank, frame_start, frame_count,
        input  tmds_0, tmds_1, tmds_2
    );
endinterface

// File: rtl/tmds_video_core.sv
// Raster timing generator feeding a three-channel DVI TMDS encoder.
// Each symbol trails the hpos/vpos it was sampled at by exactly two clocks.
module tmds_video_core #(
    parameter int unsigned H_IMAGE   = 720,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 62,
    parameter int unsigned H_BACK    = 60,
    parameter int unsigned V_IMAGE   = 480,
    parameter int unsigned V_FRONT   = 9,
    parameter int unsigned V_SYNC    = 6,
    parameter int unsigned V_BACK    = 30,
    parameter bit          H_INVERT  = 1'b1,
    parameter bit          V_INVERT  = 1'b1,
    parameter int unsigned POS_WIDTH = 11
) (
    input logic               clk,
    input logic               reset,
    tmds_video_core_if.master vid
);
    localparam int unsigned WIDTH    = H_IMAGE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned HEIGHT   = V_IMAGE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HS_START = H_IMAGE + H_FRONT;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_IMAGE + V_FRONT;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    logic [POS_WIDTH-1:0] hpos_q, vpos_q;
    logic [15:0]          frame_count_q;
    logic                 h_last, v_last;
    logic                 hblank_c, vblank_c, hsync_act, vsync_act, de_c;
    logic [1:0]           ctrl_c;
    logic                 de1_q;
    logic [1:0]           ctrl1_q;
    logic [7:0]           pix [3];

    function automatic logic [8:0] tm_encode(input logic [7:0] d);
        logic [8:0] q;
        logic [3:0] n1;
        logic       use_xnor;
        n1       = 4'($countones(d));
        use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
        q        = '0;
        q[0]     = d[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        end
        q[8] = ~use_xnor;
        return q;
    endfunction

    function automatic logic [9:0] ctrl_symbol(input logic [1:0] c);
        case (c)
            2'b00:   return 10'b1101010100;
            2'b01:   return 10'b0010101011;
            2'b10:   return 10'b0101010100;
            default: return 10'b1010101011;
        endcase
    endfunction

    // Raster position and frame counter
    assign h_last = (hpos_q == POS_WIDTH'(WIDTH - 1));
    assign v_last = (vpos_q == POS_WIDTH'(HEIGHT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hpos_q        <= '0;
            vpos_q        <= '0;
            frame_count_q <= '0;
        end else if (h_last) begin
            hpos_q <= '0;
            if (v_last) begin
                vpos_q        <= '0;
                frame_count_q <= frame_count_q + 16'd1;
            end else begin
                vpos_q <= vpos_q + POS_WIDTH'(1);
            end
        end else begin
            hpos_q <= hpos_q + POS_WIDTH'(1);
        end
    end

    assign hblank_c  = (hpos_q >= POS_WIDTH'(H_IMAGE));
    assign vblank_c  = (vpos_q >= POS_WIDTH'(V_IMAGE));
    assign hsync_act = (hpos_q >= POS_WIDTH'(HS_START)) && (hpos_q < POS_WIDTH'(HS_END));
    assign vsync_act = (vpos_q >= POS_WIDTH'(VS_START)) && (vpos_q < POS_WIDTH'(VS_END));
    assign de_c      = !(hblank_c || vblank_c);
    assign ctrl_c    = {vsync_act ^ V_INVERT, hsync_act ^ H_INVERT};

    assign vid.hpos        = hpos_q;
    assign vid.vpos        = vpos_q;
    assign vid.in_hblank   = hblank_c;
    assign vid.in_vblank   = vblank_c;
    assign vid.frame_start = (hpos_q == '0) && (vpos_q == '0);
    assign vid.frame_count = frame_count_q;

    assign pix[0] = vid.blue;
    assign pix[1] = vid.green;
    assign pix[2] = vid.red;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            de1_q   <= 1'b0;
            ctrl1_q <= '0;
        end else begin
            de1_q   <= de_c;
            ctrl1_q <= ctrl_c;
        end
    end

    // Per channel: stage 1 transition-minimises, stage 2 DC-balances
    for (genvar c = 0; c < 3; c++) begin : g_ch
        logic [8:0]        q_m_q;
        logic [9:0]        tmds_q, sym_c;
        logic signed [4:0] cnt_q, cnt_c, bal_c;
        logic [3:0]        n1_c;
        logic [1:0]        ctl_c;
        logic              q8;

        assign ctl_c = (c == 0) ? ctrl1_q : 2'b00;
        assign q8    = q_m_q[8];
        assign n1_c  = 4'($countones(q_m_q[7:0]));
        // N1 - N0 over q_m[7:0]; modulo-32 arithmetic is exact for the -8..8 range
        assign bal_c = $signed({n1_c, 1'b0}) - 5'sd8;

        always_comb begin
            sym_c = ctrl_symbol(ctl_c);
            cnt_c = '0;
            if (de1_q) begin
                if ((cnt_q == 5'sd0) || (bal_c == 5'sd0)) begin
                    sym_c = {~q8, q8, q8 ? q_m_q[7:0] : ~q_m_q[7:0]};
                    cnt_c = q8 ? (cnt_q + bal_c) : (cnt_q - bal_c);
                end else if (((cnt_q > 5'sd0) && (bal_c > 5'sd0)) ||
                             ((cnt_q < 5'sd0) && (bal_c < 5'sd0))) begin
                    sym_c = {1'b1, q8, ~q_m_q[7:0]};
                    cnt_c = cnt_q + (q8 ? 5'sd2 : 5'sd0) - bal_c;
                end else begin
                    sym_c = {1'b0, q8, q_m_q[7:0]};
                    cnt_c = cnt_q - (q8 ? 5'sd0 : 5'sd2) + bal_c;
                end
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                q_m_q  <= '0;
                tmds_q <= '0;
                cnt_q  <= '0;
            end else begin
                q_m_q  <= tm_encode(pix[c]);
                tmds_q <= sym_c;
                cnt_q  <= cnt_c;
            end
        end
    end

    assign vid.tmds_0 = g_ch[0].tmds_q;
    assign vid.tmds_1 = g_ch[1].tmds_q;
    assign vid.tmds_2 = g_ch[2].tmds_q;
endmodule

// File: tb/tb_tmds_video_core.sv
// Bench for tmds_video_core: a reduced-raster instance checked every cycle against
// an arithmetic DVI model, plus a default-raster instance pinned on line 0.
module tb_tmds_video_core;
    localparam int H_IMAGE = 40;
    localparam int H_FRONT = 6;
    localparam int H_SYNC  = 8;
    localparam int H_BACK  = 10;
    localparam int V_IMAGE = 20;
    localparam int V_FRONT = 3;
    localparam int V_SYNC  = 2;
    localparam int V_BACK  = 5;
    localparam int WIDTH   = H_IMAGE + H_FRONT + H_SYNC + H_BACK;
    localparam int HEIGHT  = V_IMAGE + V_FRONT + V_SYNC + V_BACK;

    localparam int SYM_C00 = 32'b1101010100;
    localparam int SYM_C01 = 32'b0010101011;
    localparam int SYM_C10 = 32'b0101010100;
    localparam int SYM_C11 = 32'b1010101011;
    localparam int SYM_K_A = 32'b0100000000;
    localparam int SYM_K_B = 32'b1111111111;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    tmds_video_core_if #(.POS_WIDTH(11)) vid ();
    tmds_video_core_if #(.POS_WIDTH(11)) vdef ();

    tmds_video_core #(
        .H_IMAGE(H_IMAGE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
        .V_IMAGE(V_IMAGE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK)
    ) dut (
        .clk(clk),
        .reset(reset),
        .vid(vid)
    );

    tmds_video_core u_def (
        .clk(clk),
        .reset(reset),
        .vid(vdef)
    );

    assign vdef.red   = 8'd0;
    assign vdef.green = 8'd0;
    assign vdef.blue  = 8'd0;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: raster position, frames, per-channel disparity, one-deep symbol pipe
    int m_h, m_v, m_frames, k, mode;
    int m_cnt [3];
    int pipe1 [3];
    int pix_in [3];
    bit first_run, pin_run;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s at %0t: got 0x%0h, want 0x%0h", name, $time, act, exp);
    endtask

    // DVI encoding from the closed form: q_m[i] is the parity of d[0..i],
    // flipped on odd bits when XNOR chaining is chosen.
    task automatic model_encode(input int d, input bit de, input int ctl, input int ch,
                                output int sym);
        logic [7:0] db;
        int ones, qm, n1, bal, q8, low;
        bit use_xnor;
        if (!de) begin
            m_cnt[ch] = 0;
            case (ctl)
                0:       sym = SYM_C00;
                1:       sym = SYM_C01;
                2:       sym = SYM_C10;
                default: sym = SYM_C11;
            endcase
            return;
        end
        db       = 8'(d);
        ones     = $countones(db);
        use_xnor = (ones > 4) || (ones == 4 && db[0] == 1'b0);
        qm = 0;
        for (int i = 0; i < 8; i++) begin
            int par;
            par = $countones(int'(db) & ((2 << i) - 1)) % 2;
            if (use_xnor && (i % 2 == 1)) par = 1 - par;
            qm = qm | (par << i);
        end
        q8  = use_xnor ? 0 : 1;
        low = qm & 255;
        n1  = $countones(low);
        bal = n1 - (8 - n1);
        if (m_cnt[ch] == 0 || bal == 0) begin
            if (q8 == 1) begin
                sym = 256 | low;
                m_cnt[ch] = m_cnt[ch] + bal;
            end else begin
                sym = 512 | (~low & 255);
                m_cnt[ch] = m_cnt[ch] - bal;
            end
        end else if ((m_cnt[ch] > 0 && bal > 0) || (m_cnt[ch] < 0 && bal < 0)) begin
            sym = 512 | (q8 << 8) | (~low & 255);
            m_cnt[ch] = m_cnt[ch] + 2 * q8 - bal;
        end else begin
            sym = (q8 << 8) | low;
            m_cnt[ch] = m_cnt[ch] + bal - 2 * (1 - q8);
        end
    endtask

    task automatic drive_pixels();
        for (int c = 0; c < 3; c++)
            pix_in[c] = (mode == 1) ? int'($urandom_range(0, 255)) : 0;
        vid.blue  = 8'(pix_in[0]);
        vid.green = 8'(pix_in[1]);
        vid.red   = 8'(pix_in[2]);
    endtask

    task automatic check_idle();
        check("rst_hpos", int'(vid.hpos), 0);
        check("rst_vpos", int'(vid.vpos), 0);
        check("rst_frame_count", int'(vid.frame_count), 0);
        check("rst_tmds_0", int'(vid.tmds_0), 0);
        check("rst_tmds_1", int'(vid.tmds_1), 0);
        check("rst_tmds_2", int'(vid.tmds_2), 0);
        check("rst_def_tmds_0", int'(vdef.tmds_0), 0);
        check("rst_def_hpos", int'(vdef.hpos), 0);
    endtask

    task automatic apply_reset(input int hold);
        reset = 1'b1;
        #1;
        for (int i = 0; i < hold; i++) begin
            check_idle();
            @(posedge clk);
            #1;
        end
        check_idle();
        @(negedge clk);
        reset    = 1'b0;
        m_h      = 0;
        m_v      = 0;
        m_frames = 0;
        k        = 0;
        // A cleared stage 1 holds de=0 with control 00, so that symbol leads out
        for (int c = 0; c < 3; c++) begin
            m_cnt[c] = 0;
            pipe1[c] = SYM_C00;
        end
        #1;
        check("release_frame_start", int'(vid.frame_start), 1);
        check("release_hpos", int'(vid.hpos), 0);
        drive_pixels();
    endtask

    // One clock: advance the model past the sampled pixel, then compare everything
    task automatic cycle();
        int sym [3];
        int exp_t [3];
        int ctl;
        bit de, hs, vs;
        @(posedge clk);
        #1;
        de  = (m_h < H_IMAGE) && (m_v < V_IMAGE);
        hs  = (m_h >= H_IMAGE + H_FRONT) && (m_h < H_IMAGE + H_FRONT + H_SYNC);
        vs  = (m_v >= V_IMAGE + V_FRONT) && (m_v < V_IMAGE + V_FRONT + V_SYNC);
        ctl = ((vs ? 0 : 1) << 1) | (hs ? 0 : 1);
        for (int c = 0; c < 3; c++) model_encode(pix_in[c], de, (c == 0) ? ctl : 0, c, sym[c]);
        for (int c = 0; c < 3; c++) begin
            exp_t[c] = pipe1[c];
            pipe1[c] = sym[c];
        end
        m_h++;
        if (m_h == WIDTH) begin
            m_h = 0;
            m_v++;
            if (m_v == HEIGHT) begin
                m_v      = 0;
                m_frames = (m_frames + 1) % 65536;
            end
        end
        k++;

        check("hpos", int'(vid.hpos), m_h);
        check("vpos", int'(vid.vpos), m_v);
        check("in_hblank", int'(vid.in_hblank), (m_h >= H_IMAGE) ? 1 : 0);
        check("in_vblank", int'(vid.in_vblank), (m_v >= V_IMAGE) ? 1 : 0);
        check("frame_start", int'(vid.frame_start), (m_h == 0 && m_v == 0) ? 1 : 0);
        check("frame_count", int'(vid.frame_count), m_frames);
        check("tmds_0", int'(vid.tmds_0), exp_t[0]);
        check("tmds_1", int'(vid.tmds_1), exp_t[1]);
        check("tmds_2", int'(vid.tmds_2), exp_t[2]);

        if (pin_run) begin
            case (k)
                2:    check("pin_black_first", int'(vid.tmds_0), SYM_K_A);
                3:    check("pin_black_second", int'(vid.tmds_1), SYM_K_B);
                4:    check("pin_black_third", int'(vid.tmds_2), SYM_K_A);
                47:   check("pin_front_porch_ctl", int'(vid.tmds_0), SYM_C11);
                48:   check("pin_hsync_ctl", int'(vid.tmds_0), SYM_C10);
                64:   check("pin_line_wrap_vpos", int'(vid.vpos), 1);
                66:   check("pin_line1_restart", int'(vid.tmds_0), SYM_K_A);
                1474: check("pin_vsync_ctl", int'(vid.tmds_0), SYM_C01);
                1520: check("pin_vsync_hsync_ctl", int'(vid.tmds_0), SYM_C00);
                1920: check("pin_frame_count", int'(vid.frame_count), 1);
                default: ;
            endcase
        end
        if (first_run) begin
            case (k)
                2:   check("def_black_first", int'(vdef.tmds_2), SYM_K_A);
                719: check("def_hblank_before", int'(vdef.in_hblank), 0);
                720: check("def_hblank_start", int'(vdef.in_hblank), 1);
                737: check("def_hpos735_ctl", int'(vdef.tmds_0), SYM_C11);
                738: check("def_hpos736_ctl", int'(vdef.tmds_0), SYM_C10);
                799: check("def_hpos797_ctl", int'(vdef.tmds_0), SYM_C10);
                800: check("def_hpos798_ctl", int'(vdef.tmds_0), SYM_C11);
                857: check("def_hpos_last", int'(vdef.hpos), 857);
                858: check("def_line_wrap", int'(vdef.hpos) * 1000 + int'(vdef.vpos), 1);
                default: ;
            endcase
        end
        drive_pixels();
    endtask

    initial begin
        reset     = 1'b1;
        vid.red   = 8'd0;
        vid.green = 8'd0;
        vid.blue  = 8'd0;
        mode      = 0;
        first_run = 1'b1;
        pin_run   = 1'b1;
        apply_reset(3);
        repeat (WIDTH * HEIGHT) cycle();

        first_run = 1'b0;
        pin_run   = 1'b0;
        mode      = 1;
        repeat (2 * WIDTH * HEIGHT) cycle();

        for (int i = 0; i < WIDTH * HEIGHT; i++) begin
            if (m_h == 30 && m_v == 10) break;
            cycle();
        end
        check("pre_reset_hpos", int'(vid.hpos), 30);
        check("pre_reset_vpos", int'(vid.vpos), 10);

        mode    = 0;
        pin_run = 1'b1;
        apply_reset(3);
        repeat (200) cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
